// File: rtl/nfc_page_seq_pkg.sv
// Shared definitions for the NFC page sequencer: register offsets, ECC parity
// sizes, FSM/phase encodings, the latched page descriptor and helpers.
package nfc_page_seq_pkg;

    localparam logic [8:0] NFC_IF_CTRL0_OFFSET      = 9'h004;
    localparam logic [8:0] NFC_IF_CMD_OFFSET        = 9'h008;
    localparam logic [8:0] NFC_IF_STATUS_OFFSET     = 9'h00C;
    localparam logic [8:0] NFC_ROW_ADDR0_OFFSET     = 9'h010;
    localparam logic [8:0] NFC_ROW_ADDR1_OFFSET     = 9'h011;
    localparam logic [8:0] NFC_ROW_ADDR2_OFFSET     = 9'h012;
    localparam logic [8:0] NFC_ROW_ADDR3_OFFSET     = 9'h013;
    localparam logic [8:0] NFC_COLUMN_ADDR0_OFFSET  = 9'h014;
    localparam logic [8:0] NFC_COLUMN_ADDR1_OFFSET  = 9'h015;
    localparam logic [8:0] NFC_COLUMN_ADDR2_OFFSET  = 9'h016;
    localparam logic [8:0] NFC_COLUMN_ADDR3_OFFSET  = 9'h017;
    localparam logic [8:0] NFC_ADDR_CNT_OFFSET      = 9'h018;
    localparam logic [8:0] NFC_BLK_LEN0_OFFSET      = 9'h020;
    localparam logic [8:0] NFC_BLK_LEN1_OFFSET      = 9'h021;
    localparam logic [8:0] NFC_RED_LEN_OFFSET       = 9'h022;
    localparam logic [8:0] NFC_ECC_CFG0_OFFSET      = 9'h028;
    localparam logic [8:0] NFC_ECC_CFG1_OFFSET      = 9'h029;
    localparam logic [8:0] NFC_ECC_CTRL_OFFSET      = 9'h02A;
    localparam logic [8:0] NFC_TRN_CNT0_OFFSET      = 9'h030;
    localparam logic [8:0] NFC_TRN_CNT1_OFFSET      = 9'h031;
    localparam logic [8:0] NFC_RAND_SEED3_OFFSET    = 9'h03B;

    localparam logic [7:0] NFC_ECC_PAR_T4 = 8'd7;
    localparam logic [7:0] NFC_ECC_PAR_T8 = 8'd13;
    localparam logic [7:0] NFC_IF_CTRL0_ADDR_GO = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_GAP,
        ST_POLL_RD,
        ST_POLL_CHK,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_CMD,
        PH_ADDR,
        PH_CFG
    } seq_phase_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] row_addr;
        logic [31:0] col_addr;
        logic [5:0]  addr_cnt;
        logic [9:0]  blk_len;
        logic [4:0]  red_len;
        logic        ecc_en;
        logic        ecc_t8;
        logic        ecc_enc;
        logic [7:0]  rnd_seed;
        logic [7:0]  if_ctrl;
    } seq_desc_t;

    // Bytes moved in the data phase: payload plus ECC parity when enabled.
    function automatic logic [15:0] trn_count(input seq_desc_t d);
        logic [15:0] par;
        par = 16'd0;
        if (d.ecc_en)
            par = d.ecc_t8 ? {8'd0, NFC_ECC_PAR_T8} : {8'd0, NFC_ECC_PAR_T4};
        return {6'b0, d.blk_len} + par;
    endfunction

    function automatic seq_phase_t next_phase(input seq_phase_t p);
        case (p)
            PH_CMD:  return PH_ADDR;
            default: return PH_CFG;
        endcase
    endfunction

endpackage

// File: rtl/nfc_page_seq_if.sv
// Byte-wide NFC register port: the sequencer is the master, the NFC the slave.
interface nfc_page_seq_if;
    logic [8:0] mif_nfc_reg_addr;
    logic       mif_nfc_reg_wr;
    logic       mif_nfc_reg_rd;
    logic [7:0] mif_nfc_reg_din;
    logic [7:0] nfc_mif_reg_dout;

    modport master (
        output mif_nfc_reg_addr,
        output mif_nfc_reg_wr,
        output mif_nfc_reg_rd,
        output mif_nfc_reg_din,
        input  nfc_mif_reg_dout
    );

    modport slave (
        input  mif_nfc_reg_addr,
        input  mif_nfc_reg_wr,
        input  mif_nfc_reg_rd,
        input  mif_nfc_reg_din,
        output nfc_mif_reg_dout
    );
endinterface

// File: rtl/nfc_seq_rom.sv
// Write table for each sequencer phase: maps (phase, step, descriptor) to the
// register offset, data byte and a flag marking the final write of the phase.
module nfc_seq_rom
    import nfc_page_seq_pkg::*;
(
    input  seq_phase_t phase,
    input  logic [3:0] idx,
    input  seq_desc_t  desc,
    output logic [8:0] offset,
    output logic [7:0] data,
    output logic       last
);
    logic [15:0] trn;

    assign trn = trn_count(desc);

    always_comb begin
        offset = '0;
        data   = '0;
        last   = 1'b0;
        case (phase)
            PH_CMD: begin
                offset = NFC_IF_CMD_OFFSET;
                data   = desc.cmd;
                last   = 1'b1;
            end
            PH_ADDR: begin
                case (idx)
                    4'd0: begin offset = NFC_ROW_ADDR0_OFFSET;    data = desc.row_addr[7:0];   end
                    4'd1: begin offset = NFC_ROW_ADDR1_OFFSET;    data = desc.row_addr[15:8];  end
                    4'd2: begin offset = NFC_ROW_ADDR2_OFFSET;    data = desc.row_addr[23:16]; end
                    4'd3: begin offset = NFC_ROW_ADDR3_OFFSET;    data = desc.row_addr[31:24]; end
                    4'd4: begin offset = NFC_COLUMN_ADDR0_OFFSET; data = desc.col_addr[7:0];   end
                    4'd5: begin offset = NFC_COLUMN_ADDR1_OFFSET; data = desc.col_addr[15:8];  end
                    4'd6: begin offset = NFC_COLUMN_ADDR2_OFFSET; data = desc.col_addr[23:16]; end
                    4'd7: begin offset = NFC_COLUMN_ADDR3_OFFSET; data = desc.col_addr[31:24]; end
                    4'd8: begin offset = NFC_ADDR_CNT_OFFSET;     data = {2'b0, desc.addr_cnt}; end
                    4'd9: begin
                        offset = NFC_IF_CTRL0_OFFSET;
                        data   = NFC_IF_CTRL0_ADDR_GO;
                        last   = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            PH_CFG: begin
                case (idx)
                    4'd0: begin offset = NFC_BLK_LEN0_OFFSET;   data = desc.blk_len[7:0];          end
                    4'd1: begin offset = NFC_BLK_LEN1_OFFSET;   data = {6'b0, desc.blk_len[9:8]};  end
                    4'd2: begin offset = NFC_RED_LEN_OFFSET;    data = {3'b0, desc.red_len};       end
                    4'd3: begin offset = NFC_ECC_CFG0_OFFSET;   data = desc.blk_len[7:0];          end
                    4'd4: begin offset = NFC_ECC_CFG1_OFFSET;   data = {6'b0, desc.blk_len[9:8]};  end
                    4'd5: begin
                        offset = NFC_ECC_CTRL_OFFSET;
                        data   = {5'b0, desc.ecc_enc, desc.ecc_t8, desc.ecc_en};
                    end
                    4'd6: begin offset = NFC_TRN_CNT0_OFFSET;   data = trn[7:0];      end
                    4'd7: begin offset = NFC_TRN_CNT1_OFFSET;   data = trn[15:8];     end
                    4'd8: begin offset = NFC_RAND_SEED3_OFFSET; data = desc.rnd_seed; end
                    4'd9: begin
                        offset = NFC_IF_CTRL0_OFFSET;
                        data   = desc.if_ctrl;
                        last   = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            default: last = 1'b1;
        endcase
    end
endmodule

// File: rtl/nfc_page_seq.sv
// Page-operation sequencer: latches a descriptor, replays the NFC register
// writes phase by phase and polls IF_STATUS for idle between phases.
module nfc_page_seq
    import nfc_page_seq_pkg::*;
#(
    parameter logic [15:0] POLL_MAX = 16'hFFFF,
    parameter int unsigned WR_GAP   = 1
)(
    input  logic                  nfc_clk,
    input  logic                  rst_nfc,
    input  logic                  seq_start,
    input  logic [7:0]            seq_cmd,
    input  logic [31:0]           seq_row_addr,
    input  logic [31:0]           seq_col_addr,
    input  logic [5:0]            seq_addr_cnt,
    input  logic [9:0]            seq_blk_len,
    input  logic [4:0]            seq_red_len,
    input  logic                  seq_ecc_en,
    input  logic                  seq_ecc_t8,
    input  logic                  seq_ecc_enc,
    input  logic [7:0]            seq_rnd_seed,
    input  logic [7:0]            seq_if_ctrl,
    nfc_page_seq_if.master        reg_bus,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_err
);
    seq_state_t state;
    seq_phase_t phase;
    seq_desc_t  desc_q;
    seq_desc_t  live_desc;
    logic [3:0] idx;
    logic       last_q;
    logic [15:0] poll_cnt;

    seq_phase_t rom_phase;
    logic [3:0] rom_idx;
    seq_desc_t  rom_desc;
    logic [8:0] rom_offset;
    logic [7:0] rom_data;
    logic       rom_last;

    assign live_desc = '{cmd: seq_cmd, row_addr: seq_row_addr, col_addr: seq_col_addr,
                         addr_cnt: seq_addr_cnt, blk_len: seq_blk_len, red_len: seq_red_len,
                         ecc_en: seq_ecc_en, ecc_t8: seq_ecc_t8, ecc_enc: seq_ecc_enc,
                         rnd_seed: seq_rnd_seed, if_ctrl: seq_if_ctrl};

    // The ROM looks one write ahead: on accept it sees the live descriptor,
    // and on a successful poll it sees step 0 of the following phase.
    always_comb begin
        rom_phase = phase;
        rom_idx   = idx;
        rom_desc  = desc_q;
        if (state == ST_IDLE) begin
            rom_phase = PH_CMD;
            rom_idx   = '0;
            rom_desc  = live_desc;
        end else if (state == ST_POLL_CHK) begin
            rom_phase = next_phase(phase);
            rom_idx   = '0;
        end
    end

    nfc_seq_rom u_rom (
        .phase  (rom_phase),
        .idx    (rom_idx),
        .desc   (rom_desc),
        .offset (rom_offset),
        .data   (rom_data),
        .last   (rom_last)
    );

    always_ff @(posedge nfc_clk or posedge rst_nfc) begin
        if (rst_nfc) begin
            state                    <= ST_IDLE;
            phase                    <= PH_CMD;
            desc_q                   <= '0;
            idx                      <= '0;
            last_q                   <= 1'b0;
            poll_cnt                 <= '0;
            reg_bus.mif_nfc_reg_addr <= '0;
            reg_bus.mif_nfc_reg_wr   <= 1'b0;
            reg_bus.mif_nfc_reg_rd   <= 1'b0;
            reg_bus.mif_nfc_reg_din  <= '0;
            seq_busy                 <= 1'b0;
            seq_done                 <= 1'b0;
            seq_err                  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (seq_start) begin
                        desc_q                   <= live_desc;
                        phase                    <= PH_CMD;
                        idx                      <= 4'd1;
                        last_q                   <= rom_last;
                        reg_bus.mif_nfc_reg_wr   <= 1'b1;
                        reg_bus.mif_nfc_reg_addr <= rom_offset;
                        reg_bus.mif_nfc_reg_din  <= rom_data;
                        seq_busy                 <= 1'b1;
                        state                    <= ST_WR;
                    end
                end
                ST_WR, ST_GAP: begin
                    reg_bus.mif_nfc_reg_wr   <= 1'b0;
                    reg_bus.mif_nfc_reg_addr <= '0;
                    reg_bus.mif_nfc_reg_din  <= '0;
                    if (state == ST_WR && WR_GAP != 0) begin
                        state <= ST_GAP;
                    end else if (last_q) begin
                        poll_cnt                 <= '0;
                        reg_bus.mif_nfc_reg_rd   <= 1'b1;
                        reg_bus.mif_nfc_reg_addr <= NFC_IF_STATUS_OFFSET;
                        state                    <= ST_POLL_RD;
                    end else begin
                        idx                      <= idx + 4'd1;
                        last_q                   <= rom_last;
                        reg_bus.mif_nfc_reg_wr   <= 1'b1;
                        reg_bus.mif_nfc_reg_addr <= rom_offset;
                        reg_bus.mif_nfc_reg_din  <= rom_data;
                        state                    <= ST_WR;
                    end
                end
                ST_POLL_RD: begin
                    reg_bus.mif_nfc_reg_rd   <= 1'b0;
                    reg_bus.mif_nfc_reg_addr <= '0;
                    state                    <= ST_POLL_CHK;
                end
                ST_POLL_CHK: begin
                    if (!reg_bus.nfc_mif_reg_dout[0]) begin
                        if (phase == PH_CFG) begin
                            seq_done <= 1'b1;
                            seq_busy <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            phase                    <= next_phase(phase);
                            idx                      <= 4'd1;
                            last_q                   <= rom_last;
                            reg_bus.mif_nfc_reg_wr   <= 1'b1;
                            reg_bus.mif_nfc_reg_addr <= rom_offset;
                            reg_bus.mif_nfc_reg_din  <= rom_data;
                            state                    <= ST_WR;
                        end
                    end else if (poll_cnt == POLL_MAX) begin
                        seq_err  <= 1'b1;
                        seq_busy <= 1'b0;
                        state    <= ST_ERR;
                    end else begin
                        poll_cnt                 <= poll_cnt + 16'd1;
                        reg_bus.mif_nfc_reg_rd   <= 1'b1;
                        reg_bus.mif_nfc_reg_addr <= NFC_IF_STATUS_OFFSET;
                        state                    <= ST_POLL_RD;
                    end
                end
                ST_DONE, ST_ERR: begin
                    seq_done <= 1'b0;
                    seq_err  <= 1'b0;
                    phase    <= PH_CMD;
                    idx      <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
